// File: rtl/game_pkg.sv
// game_pkg: shared FSM states, level encoding and one-hot level_start constants for game_level_ctrl.
package game_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_PLAY, S_CONFIRM, S_ADVANCE, S_WON, S_LOST} state_t;
  typedef enum logic [1:0] {LVL_NONE, LVL_EASY, LVL_MEDIUM, LVL_HARD} level_t;
  localparam logic [2:0] LS_OFF    = 3'b000;
  localparam logic [2:0] LS_EASY   = 3'b001;
  localparam logic [2:0] LS_MEDIUM = 3'b010;
  localparam logic [2:0] LS_HARD   = 3'b100;
  function automatic logic [2:0] level_onehot(level_t l);
    return l == LVL_EASY ? LS_EASY : l == LVL_MEDIUM ? LS_MEDIUM : l == LVL_HARD ? LS_HARD : LS_OFF;
  endfunction
endpackage

// File: rtl/cycle_timer.sv
// cycle_timer: loadable up-counter; tc flags an enabled cycle in which the count sits at LIMIT-1.
module cycle_timer #(
  parameter int LIMIT = 16
) (
  input  logic Clk,
  input  logic reset,
  input  logic load,
  input  logic init,
  input  logic en,
  output logic tc
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge Clk or posedge reset)
    if (reset) cnt <= '0;
    else if (load) cnt <= W'(init);
    else if (en) cnt <= cnt + 1'b1;
  assign tc = en && cnt == W'(LIMIT - 1);
endmodule

// File: rtl/game_level_ctrl.sv
// game_level_ctrl: sequences easy/medium/hard levels, confirming wins over a hold window.
// Optional per-level timeout enabled by defining LEVEL_TIMEOUT_EN.
module game_level_ctrl
  import game_pkg::*;
#(
  parameter int MAX_GUESSES    = 5,
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       start,
  input  logic       level_done,
  input  logic [2:0] guesses,
  output logic [2:0] level_start,
  output logic       level_reset,
  output logic [1:0] curr_level,
  output logic [1:0] levels_cleared,
  output logic       game_won,
  output logic       game_lost,
  output logic       busy,
  output logic       timed_out
);
  if (HOLD_CYCLES < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("game_level_ctrl: HOLD_CYCLES and TIMEOUT_CYCLES must be at least 2");
  end
  state_t state, state_n;
  level_t lvl, lvl_n;
  logic [1:0] cleared, cleared_n;
  logic in_level, hold_tc, timeout, lost_guess, restart;
  assign in_level   = state == S_PLAY || state == S_CONFIRM;
  assign lost_guess = 32'(guesses) >= MAX_GUESSES;
  assign restart    = start && (state == S_IDLE || state == S_WON || state == S_LOST);
  // hold count starts at 1 on the PLAY cycle that first sees level_done
  cycle_timer #(.LIMIT(HOLD_CYCLES)) u_hold (
    .Clk(Clk), .reset(reset),
    .load(state != S_CONFIRM || !level_done), .init(state == S_PLAY && level_done),
    .en(state == S_CONFIRM && level_done), .tc(hold_tc)
  );
`ifdef LEVEL_TIMEOUT_EN
  cycle_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .Clk(Clk), .reset(reset), .load(!in_level), .init(1'b0), .en(in_level), .tc(timeout)
  );
  always_ff @(posedge Clk or posedge reset)
    if (reset) timed_out <= 1'b0;
    else if (restart) timed_out <= 1'b0;
    else if (timeout) timed_out <= 1'b1;
`else
  assign timeout   = 1'b0;
  assign timed_out = 1'b0;
`endif
  always_ff @(posedge Clk or posedge reset)
    if (reset) begin
      state   <= S_IDLE;
      lvl     <= LVL_NONE;
      cleared <= 2'd0;
    end else begin
      state   <= state_n;
      lvl     <= lvl_n;
      cleared <= cleared_n;
    end
  always_comb begin
    state_n   = state;
    lvl_n     = lvl;
    cleared_n = cleared;
    case (state)
      S_IDLE, S_WON, S_LOST: if (start) begin
        state_n   = S_CLEAR;
        lvl_n     = LVL_EASY;
        cleared_n = 2'd0;
      end
      S_CLEAR:   state_n = S_PLAY;
      S_PLAY:    state_n = timeout ? S_LOST : level_done ? S_CONFIRM : lost_guess ? S_LOST : S_PLAY;
      S_CONFIRM: state_n = timeout ? S_LOST : !level_done ? S_PLAY : hold_tc ? S_ADVANCE : S_CONFIRM;
      S_ADVANCE: begin
        cleared_n = cleared == 2'd3 ? cleared : cleared + 2'd1;
        state_n   = lvl == LVL_HARD ? S_WON : S_CLEAR;
        lvl_n     = lvl == LVL_HARD ? lvl : level_t'(lvl + 2'd1);
      end
      default:   state_n = S_IDLE;
    endcase
  end
  assign level_start    = in_level ? level_onehot(lvl) : LS_OFF;
  assign level_reset    = state == S_CLEAR;
  assign curr_level     = lvl;
  assign levels_cleared = cleared;
  assign game_won       = state == S_WON;
  assign game_lost      = state == S_LOST;
  assign busy           = state == S_CLEAR || in_level || state == S_ADVANCE;
endmodule

// File: tb/tb_game_level_ctrl.sv
// tb_game_level_ctrl: directed self-checking bench for game_level_ctrl with default parameters.
module tb_game_level_ctrl;
  logic Clk = 1'b0;
  logic reset, start, level_done;
  logic [2:0] guesses, level_start;
  logic level_reset, game_won, game_lost, busy, timed_out;
  logic [1:0] curr_level, levels_cleared;
  int checks = 0;
  int failures = 0;
  game_level_ctrl dut (
    .Clk(Clk), .reset(reset), .start(start), .level_done(level_done), .guesses(guesses),
    .level_start(level_start), .level_reset(level_reset), .curr_level(curr_level),
    .levels_cleared(levels_cleared), .game_won(game_won), .game_lost(game_lost),
    .busy(busy), .timed_out(timed_out)
  );
  always #5 Clk = ~Clk;
  // packed view: {level_start, level_reset, curr_level, levels_cleared, game_won, game_lost, busy, timed_out}
  logic [11:0] outs;
  assign outs = {level_start, level_reset, curr_level, levels_cleared, game_won, game_lost, busy, timed_out};
  function automatic logic [11:0] ev(logic [2:0] ls, logic lr, logic [1:0] cl, logic [1:0] lc,
                                     logic gw, logic gl, logic b);
    return {ls, lr, cl, lc, gw, gl, b, 1'b0};
  endfunction
  task automatic chk(string tag, logic [11:0] obs, logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic step(int n);
    repeat (n) @(negedge Clk);
  endtask
  // entered at a PLAY negedge; returns at the negedge after ADVANCE
  task automatic win_level();
    level_done = 1'b1;
    step(16);
    level_done = 1'b0;
    step(1);
  endtask
  initial begin
    reset = 1'b1; start = 1'b0; level_done = 1'b0; guesses = 3'd0;
    step(3);
    chk("reset", outs, '0);
    reset = 1'b0;
    step(2);
    chk("idle", outs, '0);
    start = 1'b1; step(1); start = 1'b0;
    chk("clear_easy", outs, ev(3'b000, 1, 2'd1, 2'd0, 0, 0, 1));
    step(1);
    chk("play_easy", outs, ev(3'b001, 0, 2'd1, 2'd0, 0, 0, 1));
    guesses = 3'd4; step(2);
    chk("guess4_no_loss", outs, ev(3'b001, 0, 2'd1, 2'd0, 0, 0, 1));
    guesses = 3'd0;
    level_done = 1'b1; step(15);
    chk("hold15_confirm", outs, ev(3'b001, 0, 2'd1, 2'd0, 0, 0, 1));
    step(1);
    chk("advance", outs, ev(3'b000, 0, 2'd1, 2'd0, 0, 0, 1));
    level_done = 1'b0; step(1);
    chk("clear_medium", outs, ev(3'b000, 1, 2'd2, 2'd1, 0, 0, 1));
    step(1);
    chk("play_medium", outs, ev(3'b010, 0, 2'd2, 2'd1, 0, 0, 1));
    start = 1'b1; step(1); start = 1'b0;
    chk("start_ignored", outs, ev(3'b010, 0, 2'd2, 2'd1, 0, 0, 1));
    level_done = 1'b1; step(10); level_done = 1'b0; step(1);
    chk("abort_after10", outs, ev(3'b010, 0, 2'd2, 2'd1, 0, 0, 1));
    level_done = 1'b1; step(15); level_done = 1'b0; step(1);
    chk("hold_counter_cleared", outs, ev(3'b010, 0, 2'd2, 2'd1, 0, 0, 1));
    guesses = 3'd5; level_done = 1'b1; step(1);
    chk("done_beats_guesses", outs, ev(3'b010, 0, 2'd2, 2'd1, 0, 0, 1));
    level_done = 1'b0; step(2);
    chk("lost", outs, ev(3'b000, 0, 2'd2, 2'd1, 0, 1, 0));
    step(3);
    chk("lost_sticky", outs, ev(3'b000, 0, 2'd2, 2'd1, 0, 1, 0));
    guesses = 3'd0;
    start = 1'b1; step(1); start = 1'b0;
    chk("restart_from_lost", outs, ev(3'b000, 1, 2'd1, 2'd0, 0, 0, 1));
    step(1);
    win_level();
    chk("clear_medium2", outs, ev(3'b000, 1, 2'd2, 2'd1, 0, 0, 1));
    step(1);
    win_level();
    chk("clear_hard", outs, ev(3'b000, 1, 2'd3, 2'd2, 0, 0, 1));
    step(1);
    chk("play_hard", outs, ev(3'b100, 0, 2'd3, 2'd2, 0, 0, 1));
    win_level();
    chk("won", outs, ev(3'b000, 0, 2'd3, 2'd3, 1, 0, 0));
    step(2);
    chk("won_sticky", outs, ev(3'b000, 0, 2'd3, 2'd3, 1, 0, 0));
    start = 1'b1; step(1); start = 1'b0;
    chk("restart_from_won", outs, ev(3'b000, 1, 2'd1, 2'd0, 0, 0, 1));
    step(1); win_level();
    step(1); win_level();
    step(1);
    level_done = 1'b1; step(5);
    chk("mid_hard", outs, ev(3'b100, 0, 2'd3, 2'd2, 0, 0, 1));
    #2 reset = 1'b1;
    #1 chk("async_reset", outs, '0);
    level_done = 1'b0;
    step(2);
    chk("reset_held", outs, '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
